// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_timer_ctrl
// Brief    : Run/pause/over sequencing for the MM:SS play timer, seconds-tick
//            generation and 4-digit multiplexed 7-segment scan.
// Revision : 1.0 - initial release
// ============================================================================
module game_timer_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       game_over,
    output logic       sec_tick,
    output logic       timer_clr,
    output logic [1:0] state,
    input  logic [6:0] seg_sec_l,
    input  logic [6:0] seg_sec_h,
    input  logic [6:0] seg_min_l,
    input  logic [6:0] seg_min_h,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int              c_TICK_W   = $clog2(TICK_DIV);
    localparam int              c_SCAN_W   = $clog2(SCAN_DIV);
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_SCAN_W-1:0] c_SCAN_MAX = c_SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_restart;
    logic                  w_count;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic                  r_sec_tick;
    logic                  r_timer_clr;
    logic [c_SCAN_W-1:0]   r_scan_cnt;
    logic [1:0]            r_digit;
    logic [3:0]            r_an;
    logic [6:0]            r_seg;
    logic [6:0]            w_seg_sel;

    // w_count: stays in RUN with no restart, so the second counter may advance
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_restart   = 1'b1;
                end
            end
            ST_RUN: begin
                if (game_over)  w_state_nxt = ST_OVER;
                else if (start) w_restart   = 1'b1;
                else if (pause) w_state_nxt = ST_PAUSE;
                else            w_count     = 1'b1;
            end
            ST_PAUSE: begin
                if (game_over) begin
                    w_state_nxt = ST_OVER;
                end else if (start) begin
                    w_state_nxt = ST_RUN;
                    w_restart   = 1'b1;
                end else if (pause) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_OVER: begin
                if (start && !game_over) begin
                    w_state_nxt = ST_RUN;
                    w_restart   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_sec_tick  <= 1'b0;
            r_timer_clr <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer_clr <= w_restart;
            r_sec_tick  <= w_count && (r_tick_cnt == c_TICK_MAX);
            if (w_restart) begin
                r_tick_cnt <= '0;
            end else if (w_count) begin
                if (r_tick_cnt == c_TICK_MAX) r_tick_cnt <= '0;
                else                          r_tick_cnt <= r_tick_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_seg_sel = seg_sec_l;
        case (r_digit)
            2'd0:    w_seg_sel = seg_sec_l;
            2'd1:    w_seg_sel = seg_sec_h;
            2'd2:    w_seg_sel = seg_min_l;
            default: w_seg_sel = seg_min_h;
        endcase
    end

    // Scan runs in every state so the display never freezes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
            r_an       <= 4'b1110;
            r_seg      <= 7'b1111111;
        end else begin
            if (r_scan_cnt == c_SCAN_MAX) begin
                r_scan_cnt <= '0;
                r_digit    <= r_digit + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= w_seg_sel;
        end
    end

    assign state     = r_state;
    assign sec_tick  = r_sec_tick;
    assign timer_clr = r_timer_clr;
    assign an        = r_an;
    assign seg       = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_game_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_timer_ctrl
// Brief    : Scoreboard bench for game_timer_ctrl (TICK_DIV=4, SCAN_DIV=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_timer_ctrl;

    localparam int TD = 4;
    localparam int SD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       game_over = 1'b0;
    logic [6:0] seg_sec_l = 7'h01;
    logic [6:0] seg_sec_h = 7'h4F;
    logic [6:0] seg_min_l = 7'h12;
    logic [6:0] seg_min_h = 7'h06;
    logic       sec_tick;
    logic       timer_clr;
    logic [1:0] state;
    logic [6:0] seg;
    logic [3:0] an;

    game_timer_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .game_over(game_over),
        .sec_tick(sec_tick), .timer_clr(timer_clr), .state(state),
        .seg_sec_l(seg_sec_l), .seg_sec_h(seg_sec_h),
        .seg_min_l(seg_min_l), .seg_min_h(seg_min_h),
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       tick;
        logic       clr;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [6:0] pat(input int i);
        case (i)
            0:       return seg_sec_l;
            1:       return seg_sec_h;
            2:       return seg_min_l;
            default: return seg_min_h;
        endcase
    endfunction

    // Reference model: one expected output word per clock edge
    int   m_st = 0, m_cnt = 0, m_scan = 0, m_idx = 0, m_nst = 0;
    bit   m_rs, m_inc;
    exp_t m_e;
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_st = 0; m_cnt = 0; m_scan = 0; m_idx = 0;
            q.delete();
        end else begin
            m_rs = 1'b0; m_inc = 1'b0; m_nst = m_st;
            case (m_st)
                0: if (start) begin m_nst = 1; m_rs = 1'b1; end
                1: if (game_over) m_nst = 3; else if (start) m_rs = 1'b1;
                   else if (pause) m_nst = 2; else m_inc = 1'b1;
                2: if (game_over) m_nst = 3; else if (start) begin m_nst = 1; m_rs = 1'b1; end
                   else if (pause) m_nst = 1;
                default: if (start && !game_over) begin m_nst = 1; m_rs = 1'b1; end
            endcase
            m_e.st   = 2'(m_nst);
            m_e.clr  = m_rs;
            m_e.tick = m_inc && (m_cnt == TD - 1);
            m_e.an   = ~(4'b0001 << m_idx);
            m_e.seg  = pat(m_idx);
            if (m_rs) m_cnt = 0;
            else if (m_inc) m_cnt = (m_cnt + 1) % TD;
            if (m_scan == SD - 1) begin m_scan = 0; m_idx = (m_idx + 1) % 4; end
            else m_scan = m_scan + 1;
            m_st = m_nst;
            q.push_back(m_e);
        end
    end

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({state, sec_tick, timer_clr, an, seg} !== {2'd0, 1'b0, 1'b0, 4'b1110, 7'h7F})
            $display("FAIL reset_values: got %h exp %h", {state, sec_tick, timer_clr, an, seg},
                     {2'd0, 1'b0, 1'b0, 4'b1110, 7'h7F});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_scan(input string tag, input bit do_pause, input bit go);
        exp_t       e;
        logic [3:0] prev_an;
        logic [6:0] want;
        int         run;
        bit         seen_change;
        prev_an = an; run = 0; seen_change = 1'b0;
        for (int c = 0; c < 15; c++) begin
            pause = do_pause && (c == 0);
            game_over = go;
            @(negedge clk);
            pause = 1'b0;
            n_checks++;
            if (q.size() == 0) $display("FAIL scan_%s_model: no expected entry", tag);
            else begin
                e = q.pop_front();
                if ({state, sec_tick, timer_clr, an, seg} !== e)
                    $display("FAIL scan_%s_c%0d: got %h exp %h", tag, c,
                             {state, sec_tick, timer_clr, an, seg}, e);
                else n_pass++;
            end
            case (an)
                4'b1110: want = 7'h01;
                4'b1101: want = 7'h4F;
                4'b1011: want = 7'h12;
                default: want = 7'h06;
            endcase
            n_checks++;
            if (seg !== want) $display("FAIL scan_%s_seg_c%0d: got %h exp %h", tag, c, seg, want);
            else n_pass++;
            if (an !== prev_an) begin
                n_checks++;
                if (an !== {prev_an[2:0], prev_an[3]})
                    $display("FAIL scan_%s_order_c%0d: got %b exp %b", tag, c, an,
                             {prev_an[2:0], prev_an[3]});
                else n_pass++;
                if (seen_change) begin
                    n_checks++;
                    if (run !== 3) $display("FAIL scan_%s_dwell: got %0d exp 3", tag, run);
                    else n_pass++;
                end
                seen_change = 1'b1;
                run = 1;
            end else run++;
            prev_an = an;
        end
    endtask

    task automatic test_start();
        exp_t        e;
        logic [31:0] ticks = '0;
        for (int c = 0; c < 14; c++) begin
            start = (c == 0);
            @(negedge clk);
            start = 1'b0;
            ticks[c+1] = sec_tick;
            n_checks++;
            if (q.size() == 0) $display("FAIL start_model: no expected entry");
            else begin
                e = q.pop_front();
                if ({state, sec_tick, timer_clr, an, seg} !== e)
                    $display("FAIL start_c%0d: got %h exp %h", c, {state, sec_tick, timer_clr, an, seg}, e);
                else n_pass++;
            end
            if (c == 0) begin
                n_checks++;
                if ({state, timer_clr} !== 3'b011)
                    $display("FAIL start_clr: got state=%0d clr=%b exp state=1 clr=1", state, timer_clr);
                else n_pass++;
            end
        end
        n_checks++;
        if (ticks !== 32'h0000_2220) $display("FAIL start_tick_cycles: got %h exp %h", ticks, 32'h2220);
        else n_pass++;
    endtask

    task automatic test_pause();
        exp_t e;
        for (int c = 0; c < 28; c++) begin
            start = (c == 0);
            pause = (c == 4) || (c == 24);
            @(negedge clk);
            start = 1'b0; pause = 1'b0;
            n_checks++;
            if (q.size() == 0) $display("FAIL pause_model: no expected entry");
            else begin
                e = q.pop_front();
                if ({state, sec_tick, timer_clr, an, seg} !== e)
                    $display("FAIL pause_c%0d: got %h exp %h", c, {state, sec_tick, timer_clr, an, seg}, e);
                else n_pass++;
            end
            if (c >= 4 && c <= 23) begin
                n_checks++;
                if ({state, sec_tick} !== 3'b100)
                    $display("FAIL pause_hold_c%0d: got state=%0d tick=%b exp state=2 tick=0", c, state, sec_tick);
                else n_pass++;
            end
            if (c == 24 || c == 25) begin
                n_checks++;
                if ({state, sec_tick} !== {2'd1, c == 25})
                    $display("FAIL pause_resume_c%0d: got state=%0d tick=%b exp state=1 tick=%0d",
                             c, state, sec_tick, c == 25);
                else n_pass++;
            end
        end
    endtask

    task automatic test_over();
        exp_t e;
        for (int c = 0; c < 15; c++) begin
            start = (c == 0) || (c == 6) || (c == 9);
            game_over = (c >= 4 && c <= 7);
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (q.size() == 0) $display("FAIL over_model: no expected entry");
            else begin
                e = q.pop_front();
                if ({state, sec_tick, timer_clr, an, seg} !== e)
                    $display("FAIL over_c%0d: got %h exp %h", c, {state, sec_tick, timer_clr, an, seg}, e);
                else n_pass++;
            end
            if (c == 4 || c == 6 || c == 9) begin
                n_checks++;
                if ({state, sec_tick, timer_clr} !== ((c == 9) ? 4'b0101 : 4'b1100))
                    $display("FAIL over_c%0d: got state=%0d tick=%b clr=%b exp %b", c, state, sec_tick,
                             timer_clr, (c == 9) ? 4'b0101 : 4'b1100);
                else n_pass++;
            end
        end
        game_over = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] ticks = '0;
        logic [31:0] clrs = '0;
        for (int c = 0; c < 12; c++) begin
            start = (c == 0) || (c == 3);
            @(negedge clk);
            start = 1'b0;
            ticks[c+1] = sec_tick;
            clrs[c+1]  = timer_clr;
            n_checks++;
            if (q.size() == 0) $display("FAIL restart_model: no expected entry");
            else begin
                e = q.pop_front();
                if ({state, sec_tick, timer_clr, an, seg} !== e)
                    $display("FAIL restart_c%0d: got %h exp %h", c, {state, sec_tick, timer_clr, an, seg}, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (ticks !== 32'h0000_1100) $display("FAIL restart_ticks: got %h exp %h", ticks, 32'h1100);
        else n_pass++;
        n_checks++;
        if (clrs !== 32'h0000_0012) $display("FAIL restart_clrs: got %h exp %h", clrs, 32'h12);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        exp_t e;
        n_checks++;
        if (state !== 2'd1) $display("FAIL areset_pre: got state=%0d exp 1", state);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({state, sec_tick, timer_clr, an, seg} !== {2'd0, 1'b0, 1'b0, 4'b1110, 7'h7F})
            $display("FAIL areset_values: got %h exp %h", {state, sec_tick, timer_clr, an, seg},
                     {2'd0, 1'b0, 1'b0, 4'b1110, 7'h7F});
        else n_pass++;
        game_over = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (q.size() == 0) $display("FAIL areset_model: no expected entry");
            else begin
                e = q.pop_front();
                if ({state, sec_tick, timer_clr, an, seg} !== e || state !== 2'd0)
                    $display("FAIL areset_idle_c%0d: got %h exp %h", c, {state, sec_tick, timer_clr, an, seg}, e);
                else n_pass++;
            end
        end
        game_over = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan("idle", 1'b0, 1'b0);
        test_start();
        test_pause();
        test_scan("pause", 1'b1, 1'b0);
        test_back_to_back();
        test_over();
        test_scan("over", 1'b0, 1'b1);
        game_over = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        void'(q.pop_front());
        @(negedge clk);
        void'(q.pop_front());
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
